// File: rtl/apu_envelope_length_unit.sv
// Per-channel envelope generator, length counter and register-0/3 write decode for APU pulse/noise channels.
// Optional build macro APU_LEN_GATE_EN: forces vol_out to 0 whenever the length counter is 0.
module apu_envelope_length_unit #(
  parameter logic [1:0] ENV_REG_ADDR = 2'b00,
  parameter logic [1:0] LEN_REG_ADDR = 2'b11
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       e_pulse_in,
  input  logic       l_pulse_in,
  input  logic       en_in,
  input  logic       wr_in,
  input  logic [1:0] a_in,
  input  logic [7:0] d_in,
  output logic [1:0] duty_out,
  output logic [3:0] vol_out,
  output logic       len_nonzero_out
);

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;  5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;  5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;  5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;  5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;  5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;  5'd31: v = 8'd30;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  logic [1:0] duty_q,   duty_d;
  logic       halt_q,   halt_d;
  logic       cvol_q,   cvol_d;
  logic [3:0] period_q, period_d;
  logic [7:0] len_q,    len_d;
  logic [3:0] decay_q,  decay_d;
  logic [3:0] div_q,    div_d;
  logic       start_q,  start_d;
  logic       env_wr_s, len_wr_s;
  logic [3:0] vol_s;

  assign env_wr_s = wr_in && (a_in == ENV_REG_ADDR);
  assign len_wr_s = wr_in && (a_in == LEN_REG_ADDR);

  // Next-state: register decode, length counter and envelope step, all using pre-edge state
  always_comb begin
    duty_d   = duty_q;
    halt_d   = halt_q;
    cvol_d   = cvol_q;
    period_d = period_q;
    len_d    = len_q;
    decay_d  = decay_q;
    div_d    = div_q;
    start_d  = start_q;

    if (env_wr_s) begin
      duty_d   = d_in[7:6];
      halt_d   = d_in[5];
      cvol_d   = d_in[4];
      period_d = d_in[3:0];
    end else begin
      duty_d   = duty_q;
    end

    if (!en_in) begin
      len_d = 8'd0;
    end else if (len_wr_s) begin
      len_d = len_lut(d_in[7:3]);
    end else if (l_pulse_in && !halt_q && (len_q != 8'd0)) begin
      len_d = len_q - 8'd1;
    end else begin
      len_d = len_q;
    end

    // The old start flag drives this step; a coincident reg3 write re-arms it afterwards
    if (e_pulse_in) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = 4'd15;
        div_d   = period_q;
      end else if (div_q == 4'd0) begin
        div_d = period_q;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (halt_q) begin
          decay_d = 4'd15;
        end else begin
          decay_d = 4'd0;
        end
      end else begin
        div_d = div_q - 4'd1;
      end
    end else begin
      div_d = div_q;
    end

    if (len_wr_s) begin
      start_d = 1'b1;
    end else begin
      start_d = start_d;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      duty_q   <= 2'd0;
      halt_q   <= 1'b0;
      cvol_q   <= 1'b0;
      period_q <= 4'd0;
      len_q    <= 8'd0;
      decay_q  <= 4'd0;
      div_q    <= 4'd0;
      start_q  <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      halt_q   <= halt_d;
      cvol_q   <= cvol_d;
      period_q <= period_d;
      len_q    <= len_d;
      decay_q  <= decay_d;
      div_q    <= div_d;
      start_q  <= start_d;
    end
  end

  // Output selection from registered state only
  always_comb begin
    vol_s = cvol_q ? period_q : decay_q;
`ifdef APU_LEN_GATE_EN
    if (len_q == 8'd0) begin
      vol_out = 4'd0;
    end else begin
      vol_out = vol_s;
    end
`else
    vol_out = vol_s;
`endif
  end

  assign duty_out        = duty_q;
  assign len_nonzero_out = (len_q != 8'd0);

endmodule

// File: tb/tb_apu_envelope_length_unit.sv
// Scoreboard bench for apu_envelope_length_unit: directed test-plan sequences followed by random traffic.
module tb_apu_envelope_length_unit;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       e_pulse_in = 1'b0, l_pulse_in = 1'b0, en_in = 1'b0, wr_in = 1'b0;
  logic [1:0] a_in = 2'd0;
  logic [7:0] d_in = 8'd0;
  logic [1:0] duty_out;
  logic [3:0] vol_out;
  logic       len_nonzero_out;

  apu_envelope_length_unit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .e_pulse_in(e_pulse_in), .l_pulse_in(l_pulse_in),
    .en_in(en_in), .wr_in(wr_in), .a_in(a_in), .d_in(d_in),
    .duty_out(duty_out), .vol_out(vol_out), .len_nonzero_out(len_nonzero_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int duty; int vol; int lnz; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  bit   chk_en = 1'b0;

  int lut [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                   12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int m_duty, m_halt, m_const, m_per, m_len, m_decay, m_div, m_start;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.duty = m_duty;
    e.vol  = (m_const != 0) ? m_per : m_decay;
`ifdef APU_LEN_GATE_EN
    if (m_len == 0) e.vol = 0;
`endif
    e.lnz  = (m_len != 0) ? 1 : 0;
    return e;
  endfunction

  task automatic model_reset();
    m_duty = 0; m_halt = 0; m_const = 0; m_per = 0;
    m_len = 0; m_decay = 0; m_div = 0; m_start = 0;
  endtask

  // Reference behaviour for one clock edge, expressed directly from the channel rules
  task automatic model_step(input int e, input int l, input int en, input int wr, input int a, input int d);
    int new_len;
    bit len_wr, env_wr;
    env_wr = (wr != 0) && (a == 0);
    len_wr = (wr != 0) && (a == 3);
    new_len = m_len;
    if (en == 0) new_len = 0;
    else if (len_wr) new_len = lut[(d >> 3) & 31];
    else if (l != 0 && m_halt == 0 && m_len > 0) new_len = m_len - 1;
    if (e != 0) begin
      if (m_start != 0) begin
        m_start = 0; m_decay = 15; m_div = m_per;
      end else if (m_div == 0) begin
        m_div = m_per;
        if (m_decay > 0) m_decay = m_decay - 1;
        else if (m_halt != 0) m_decay = 15;
      end else m_div = m_div - 1;
    end
    if (len_wr) m_start = 1;
    if (env_wr) begin
      m_duty = (d >> 6) & 3; m_halt = (d >> 5) & 1; m_const = (d >> 4) & 1; m_per = d & 15;
    end
    m_len = new_len;
  endtask

  task automatic cycle(input int e, input int l, input int en, input int wr, input int a, input int d);
    @(negedge clk_in);
    e_pulse_in = e[0]; l_pulse_in = l[0]; en_in = en[0]; wr_in = wr[0];
    a_in = a[1:0]; d_in = d[7:0];
    @(posedge clk_in);
    model_step(e, l, en, wr, a, d);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    chk_en = 1'b0;
    e_pulse_in = 1'b0; l_pulse_in = 1'b0; en_in = 1'b0; wr_in = 1'b0; a_in = 2'd0; d_in = 8'd0;
    #1;
    chk("reset_duty", int'(duty_out), 0);
    chk("reset_vol", int'(vol_out), 0);
    chk("reset_lnz", int'(len_nonzero_out), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    chk_en = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents settled outputs, compare against the oldest expectation
  always @(negedge clk_in) begin
    if (chk_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("duty", int'(duty_out), mon_e.duty);
      chk("vol", int'(vol_out), mon_e.vol);
      chk("len_nonzero", int'(len_nonzero_out), mon_e.lnz);
    end
  end

  initial begin
    model_reset();
    #1;
    chk("por_duty", int'(duty_out), 0);
    chk("por_vol", int'(vol_out), 0);
    chk("por_lnz", int'(len_nonzero_out), 0);
    do_reset();
    idle(2);

    // Constant volume with halt: length must not move
    cycle(0, 0, 1, 1, 0, 8'hBF);
    cycle(0, 0, 1, 1, 3, 8'h08);
    for (int i = 0; i < 10; i++) begin cycle(0, 1, 1, 0, 0, 0); idle(1); end

    // Length expiry after two half-frames
    cycle(0, 0, 1, 1, 0, 8'h15);
    cycle(0, 0, 1, 1, 3, 8'h18);
    cycle(0, 1, 1, 0, 0, 0); idle(1);
    cycle(0, 1, 1, 0, 0, 0); idle(2);

    // Envelope decay, then looping decay
    cycle(0, 0, 1, 1, 0, 8'h02);
    cycle(0, 0, 1, 1, 3, 8'h08);
    for (int i = 0; i < 52; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 8'h22);
    cycle(0, 0, 1, 1, 3, 8'h08);
    for (int i = 0; i < 60; i++) cycle(1, 0, 1, 0, 0, 0);

    // Enable interaction
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 1, 3, 8'h08);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Collisions: reg3 write with l_pulse, then with e_pulse
    cycle(0, 0, 1, 1, 3, 8'h08);
    cycle(0, 1, 1, 1, 3, 8'h08);
    idle(1);
    cycle(1, 0, 1, 1, 3, 8'h08);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 8'h31);
    cycle(1, 0, 1, 1, 0, 8'h3F);
    idle(2);

    do_reset();
    idle(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int e, l, en, wr, a, d;
      e  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      l  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      en = ($urandom_range(0, 19) == 0) ? 0 : 1;
      wr = ($urandom_range(0, 5) == 0) ? 1 : 0;
      a  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 255));
      cycle(e, l, en, wr, a, d);
      if (i == 1500) do_reset();
    end
    idle(2);
    @(negedge clk_in);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
